// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_display
//  Description : Multiplexed seven-segment scanner for NDIG common-anode
//                digits. It has a programmable refresh prescaler and a
//                load-strobed shadow register, so a digit never shows a mix
//                of old and new data. It also supports per-digit decimal
//                points, leading-zero blanking and per-digit blink.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_display #(
   parameter int NDIG         = 8,
   parameter int DIV          = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              load,
   input  logic [4*NDIG-1:0] data_in,
   input  logic [NDIG-1:0]   dp_in,
   input  logic              lzb,
   input  logic [NDIG-1:0]   blink_mask,
   output logic [7:0]        seg,
   output logic [NDIG-1:0]   AN,
   output logic              frame_tick
);

   // Counter widths; each counter is at least one bit wide so DIV=1 or
   // BLINK_FRAMES=1 still elaborate.
   localparam int c_CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int c_IW = $clog2(NDIG);
   localparam int c_FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DIV - 1);
   localparam logic [c_IW-1:0] c_IDX_MAX = c_IW'(NDIG - 1);
   localparam logic [c_FW-1:0] c_FRM_MAX = c_FW'(BLINK_FRAMES - 1);
   localparam logic [NDIG-1:0] c_ONE     = NDIG'(1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [c_CW-1:0]   r_cnt;
   logic [c_IW-1:0]   r_idx;
   logic [c_FW-1:0]   r_frame;
   logic              r_phase;
   logic [4*NDIG-1:0] r_shadow_data;
   logic [NDIG-1:0]   r_shadow_dp;
   logic [NDIG-1:0]   r_an;
   logic [7:0]        r_seg;
   logic              r_frame_tick;

   // ------------------------------------------------------------------------
   // Combinational
   // ------------------------------------------------------------------------
   logic              w_tick;
   logic              w_wrap;
   logic [3:0]        w_nib [NDIG];
   logic [NDIG-1:0]   w_upper_zero;
   logic [3:0]        w_cur_nib;
   logic              w_blank;
   logic [6:0]        w_font;
   logic [NDIG-1:0]   w_an_next;
   logic [7:0]        w_seg_next;

   // The slot ends on the last prescaler count.
   assign w_tick = (r_cnt == c_CNT_MAX);
   // The frame ends when the last digit's slot ends.
   assign w_wrap = w_tick && (r_idx == c_IDX_MAX);

   // Prescaler: one tick every DIV clocks.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_cnt <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Digit scan index: advances on every tick and wraps after the last digit.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_idx <= '0;
      end else if (w_tick) begin
         if (r_idx == c_IDX_MAX) begin
            r_idx <= '0;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   // Frame pulse: high for the single cycle after the scan wraps.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= w_wrap;
      end
   end

   // Blink timebase: counts frames and toggles the phase every BLINK_FRAMES frames.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_frame <= '0;
         r_phase <= 1'b0;
      end else if (w_wrap) begin
         if (r_frame == c_FRM_MAX) begin
            r_frame <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_frame <= r_frame + 1'b1;
         end
      end
   end

   // Shadow registers: capture the whole value at once so the scan never shows a torn value.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_shadow_data <= '0;
         r_shadow_dp   <= '0;
      end else if (load) begin
         r_shadow_data <= data_in;
         r_shadow_dp   <= dp_in;
      end
   end

   // Split the shadow word into nibbles; digit 0 is the least significant.
   generate
      for (genvar i = 0; i < NDIG; i++) begin : g_nib
         assign w_nib[i] = r_shadow_data[4*i +: 4];
      end
   endgenerate

   // w_upper_zero[i] is set when nibbles i..NDIG-1 are all zero, so it is
   // built as a chain from the most significant digit down.
   assign w_upper_zero[NDIG-1] = (w_nib[NDIG-1] == 4'h0);
   generate
      for (genvar i = 0; i < NDIG - 1; i++) begin : g_lzchain
         assign w_upper_zero[i] = (w_nib[i] == 4'h0) && w_upper_zero[i+1];
      end
   endgenerate

   assign w_cur_nib = w_nib[r_idx];

   // Blank the current digit for a leading zero (never digit 0) or for the dark blink phase.
   always_comb begin
      w_blank = 1'b0;
      if (lzb && (r_idx != '0) && w_upper_zero[r_idx]) begin
         w_blank = 1'b1;
      end
      if (blink_mask[r_idx] && r_phase) begin
         w_blank = 1'b1;
      end
   end

   // Hex font, segment order abcdefg, active-low.
   always_comb begin
      w_font = 7'b1111111;
      case (w_cur_nib)
         4'h0: w_font = 7'b0000001;
         4'h1: w_font = 7'b1001111;
         4'h2: w_font = 7'b0010010;
         4'h3: w_font = 7'b0000110;
         4'h4: w_font = 7'b1001100;
         4'h5: w_font = 7'b0100100;
         4'h6: w_font = 7'b0100000;
         4'h7: w_font = 7'b0001111;
         4'h8: w_font = 7'b0000000;
         4'h9: w_font = 7'b0000100;
         4'hA: w_font = 7'b0001000;
         4'hB: w_font = 7'b1100000;
         4'hC: w_font = 7'b0110001;
         4'hD: w_font = 7'b1000010;
         4'hE: w_font = 7'b0110000;
         4'hF: w_font = 7'b0111000;
         default: w_font = 7'b1111111;
      endcase
   end

   // Next pin values. A blanked digit drives every anode and segment high, so
   // at most one anode is ever low.
   always_comb begin
      w_an_next  = '1;
      w_seg_next = 8'hFF;
      if (!w_blank) begin
         w_an_next  = ~(c_ONE << r_idx);
         w_seg_next = {w_font, ~r_shadow_dp[r_idx]};
      end
   end

   // Output register: the pins change only on a clock edge and go dark on reset.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_an  <= '1;
         r_seg <= 8'hFF;
      end else begin
         r_an  <= w_an_next;
         r_seg <= w_seg_next;
      end
   end

   assign AN         = r_an;
   assign seg        = r_seg;
   assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_display
//  Description : Self-checking bench for seg_scan_display with NDIG=8, DIV=4
//                and BLINK_FRAMES=2. Vector table plus multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_display;

   localparam int NDIG         = 8;
   localparam int DIV          = 4;
   localparam int BLINK_FRAMES = 2;

   logic              clk        = 1'b0;
   logic              clr        = 1'b0;
   logic              load       = 1'b0;
   logic [4*NDIG-1:0] data_in    = '0;
   logic [NDIG-1:0]   dp_in      = '0;
   logic              lzb        = 1'b0;
   logic [NDIG-1:0]   blink_mask = '0;
   logic [7:0]        seg;
   logic [NDIG-1:0]   AN;
   logic              frame_tick;

   seg_scan_display #(
      .NDIG         (NDIG),
      .DIV          (DIV),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .load       (load),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .lzb        (lzb),
      .blink_mask (blink_mask),
      .seg        (seg),
      .AN         (AN),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   // Clock edges counted since the last reset release.
   int cyc;
   always @(posedge clk or posedge clr) begin
      if (clr) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  dp;
      logic        lzb;
      logic [7:0]  blink;
      int          digit;
      logic [7:0]  an;
      logic [7:0]  seg;
      string       name;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [31:0] d, input logic [7:0] p, input logic z,
                               input logic [7:0] b, input int g, input logic [7:0] a,
                               input logic [7:0] s, input string n);
      vec_t v;
      v.data = d; v.dp = p; v.lzb = z; v.blink = b; v.digit = g;
      v.an = a; v.seg = s; v.name = n;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Return at the falling edge after rising edge n since reset release.
   task automatic to_edge(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Reset, then load the given inputs on the first edge after release.
   task automatic restart(input logic [31:0] d, input logic [7:0] p,
                          input logic z, input logic [7:0] b);
      clr        = 1'b1;
      data_in    = d;
      dp_in      = p;
      lzb        = z;
      blink_mask = b;
      @(negedge clk);
      clr  = 1'b0;
      load = 1'b1;
      to_edge(1);
      load = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      logic dark;

      // ---------------- table ----------------
      vecs.push_back(mk(32'h1234ABCD, 8'h00, 1'b0, 8'h00, 0, 8'hFE, 8'h85, "scan_d0"));
      vecs.push_back(mk(32'h1234ABCD, 8'h00, 1'b0, 8'h00, 1, 8'hFD, 8'h63, "scan_d1"));
      vecs.push_back(mk(32'h1234ABCD, 8'h00, 1'b0, 8'h00, 2, 8'hFB, 8'hC1, "scan_d2"));
      vecs.push_back(mk(32'h1234ABCD, 8'h00, 1'b0, 8'hFF, 3, 8'hF7, 8'h11, "scan_d3_blinkph0"));
      vecs.push_back(mk(32'h1234ABCD, 8'h00, 1'b0, 8'h00, 4, 8'hEF, 8'h99, "scan_d4"));
      vecs.push_back(mk(32'h1234ABCD, 8'h00, 1'b0, 8'h00, 5, 8'hDF, 8'h0D, "scan_d5"));
      vecs.push_back(mk(32'h1234ABCD, 8'h00, 1'b0, 8'h00, 6, 8'hBF, 8'h25, "scan_d6"));
      vecs.push_back(mk(32'h1234ABCD, 8'h00, 1'b0, 8'h00, 7, 8'h7F, 8'h9F, "scan_d7"));
      vecs.push_back(mk(32'h00000050, 8'h00, 1'b1, 8'h00, 0, 8'hFE, 8'h03, "lzb_d0"));
      vecs.push_back(mk(32'h00000050, 8'h00, 1'b1, 8'h00, 1, 8'hFD, 8'h49, "lzb_d1"));
      vecs.push_back(mk(32'h00000050, 8'h00, 1'b1, 8'h00, 2, 8'hFF, 8'hFF, "lzb_d2"));
      vecs.push_back(mk(32'h00000050, 8'h00, 1'b1, 8'h00, 7, 8'hFF, 8'hFF, "lzb_d7"));
      vecs.push_back(mk(32'h00000050, 8'h00, 1'b0, 8'h00, 7, 8'h7F, 8'h03, "nolzb_d7"));
      vecs.push_back(mk(32'h00100000, 8'h00, 1'b1, 8'h00, 4, 8'hEF, 8'h03, "lzb_inner0"));
      vecs.push_back(mk(32'h00100000, 8'h00, 1'b1, 8'h00, 5, 8'hDF, 8'h9F, "lzb_top1"));
      vecs.push_back(mk(32'h00100000, 8'h00, 1'b1, 8'h00, 6, 8'hFF, 8'hFF, "lzb_above"));
      vecs.push_back(mk(32'h00000000, 8'h00, 1'b1, 8'h00, 0, 8'hFE, 8'h03, "lzb_allzero_d0"));
      vecs.push_back(mk(32'h00000000, 8'h00, 1'b1, 8'h00, 1, 8'hFF, 8'hFF, "lzb_allzero_d1"));
      vecs.push_back(mk(32'h89EF5670, 8'h02, 1'b0, 8'h00, 0, 8'hFE, 8'h03, "font_d0"));
      vecs.push_back(mk(32'h89EF5670, 8'h02, 1'b0, 8'h00, 1, 8'hFD, 8'h1E, "font_d1_dp"));
      vecs.push_back(mk(32'h89EF5670, 8'h02, 1'b0, 8'h00, 2, 8'hFB, 8'h41, "font_d2"));
      vecs.push_back(mk(32'h89EF5670, 8'h02, 1'b0, 8'h00, 4, 8'hEF, 8'h71, "font_d4"));
      vecs.push_back(mk(32'h89EF5670, 8'h02, 1'b0, 8'h00, 5, 8'hDF, 8'h61, "font_d5"));
      vecs.push_back(mk(32'h89EF5670, 8'h02, 1'b0, 8'h00, 6, 8'hBF, 8'h09, "font_d6"));
      vecs.push_back(mk(32'h89EF5670, 8'h02, 1'b0, 8'h00, 7, 8'h7F, 8'h01, "font_d7"));

      // ---------------- reset state and release ----------------
      #1 clr = 1'b1;
      #2;
      chk("rst_an", 32'(AN), 32'hFF);
      chk("rst_seg", 32'(seg), 32'hFF);
      chk("rst_ftick", 32'(frame_tick), 32'h0);
      @(negedge clk);
      clr = 1'b0;
      to_edge(1);
      chk("rel_an", 32'(AN), 32'hFE);
      chk("rel_seg", 32'(seg), 32'h03);
      to_edge(4);
      chk("rel_slot_end_an", 32'(AN), 32'hFE);
      to_edge(5);
      chk("rel_next_digit_an", 32'(AN), 32'hFD);

      // ---------------- vector table ----------------
      foreach (vecs[k]) begin
         restart(vecs[k].data, vecs[k].dp, vecs[k].lzb, vecs[k].blink);
         to_edge(4 * vecs[k].digit + 4);
         chk({vecs[k].name, "_an"}, 32'(AN), 32'(vecs[k].an));
         chk({vecs[k].name, "_seg"}, 32'(seg), 32'(vecs[k].seg));
      end

      // ---------------- frame_tick cadence ----------------
      restart(32'h0, 8'h00, 1'b0, 8'h00);
      to_edge(31);
      chk("ftick_before", 32'(frame_tick), 32'h0);
      to_edge(32);
      chk("ftick_wrap", 32'(frame_tick), 32'h1);
      to_edge(33);
      chk("ftick_one_cycle", 32'(frame_tick), 32'h0);
      pulses = 0;
      for (int n = 34; n <= 96; n++) begin
         to_edge(n);
         if (frame_tick) pulses++;
      end
      chk("ftick_count", 32'(pulses), 32'd2);

      // ---------------- dp and blink over eight frames ----------------
      restart(32'h89EF5670, 8'h02, 1'b0, 8'h01);
      for (int f = 0; f < 8; f++) begin
         dark = (f % 4) >= 2;
         to_edge(32 * f + 2);
         chk($sformatf("blink_f%0d_an", f), 32'(AN), dark ? 32'hFF : 32'hFE);
         chk($sformatf("blink_f%0d_seg", f), 32'(seg), dark ? 32'hFF : 32'h03);
         if (f == 2) begin
            to_edge(32 * f + 6);
            chk("blink_other_digit_dp", 32'(seg), 32'h1E);
         end
      end

      // ---------------- load coincident with tick ----------------
      restart(32'h11111111, 8'h00, 1'b0, 8'h00);
      to_edge(3);
      data_in = 32'h22222222;
      load    = 1'b1;
      to_edge(4);
      load    = 1'b0;
      chk("coinc_old_an", 32'(AN), 32'hFE);
      chk("coinc_old_seg", 32'(seg), 32'h9F);
      to_edge(5);
      chk("coinc_new_an", 32'(AN), 32'hFD);
      chk("coinc_new_seg", 32'(seg), 32'h25);
      data_in = 32'h33333333;
      to_edge(9);
      chk("noload_hold_an", 32'(AN), 32'hFB);
      chk("noload_hold_seg", 32'(seg), 32'h25);

      // ---------------- reset mid-frame ----------------
      restart(32'h1234ABCD, 8'h00, 1'b0, 8'h00);
      to_edge(22);
      chk("mid_idx5_an", 32'(AN), 32'hDF);
      #2 clr = 1'b1;
      #1;
      chk("mid_async_an", 32'(AN), 32'hFF);
      chk("mid_async_seg", 32'(seg), 32'hFF);
      @(negedge clk);
      clr = 1'b0;
      to_edge(1);
      chk("mid_restart_an", 32'(AN), 32'hFE);
      chk("mid_restart_seg", 32'(seg), 32'h03);
      to_edge(29);
      chk("mid_shadow_clear_an", 32'(AN), 32'h7F);
      chk("mid_shadow_clear_seg", 32'(seg), 32'h03);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
